// File: rtl/ref_mem_loader_pkg.sv
// ----------------------------------------------------------------------------
// ref_mem_pkg
// Shared constants and types for the reference-memory write loader.
//   PIXEL     : bits per pixel
//   BANKS     : banks in the reference memory (ROW_GROUP row slots x COL_SLOTS)
//   DEPTH     : entries per bank, one entry = 8 pixels of one row
//   AW        : bank address width
//   ROW_GROUP : rows sharing one bank entry (row slots)
//   COL_SLOTS : banks covered by one row (8 pixels each)
//   state_t   : loader FSM states
// ----------------------------------------------------------------------------
package ref_mem_pkg;

    localparam int PIXEL     = 8;
    localparam int BANKS     = 32;
    localparam int DEPTH     = 96;
    localparam int AW        = 7;
    localparam int ROW_GROUP = 8;
    localparam int COL_SLOTS = 4;

    localparam int ROW_W  = BANKS * PIXEL;        // one full row of pixels
    localparam int SLOT_W = $clog2(ROW_GROUP);    // row-slot index width
    localparam int CNT_W  = 10;                   // row count, up to 8*DEPTH

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : ref_mem_pkg

// File: rtl/ref_mem_loader_if.sv
// ----------------------------------------------------------------------------
// ref_mem_loader_if
// Valid/ready pixel-row stream feeding the reference-memory loader.
//   pix_in    : one row of BANKS*PIXEL bits, pixel 0 in the LSBs
//   pix_valid : pix_in valid (driven by the row producer)
//   pix_ready : loader can accept pix_in (driven by the loader)
// Modports: master = row producer, slave = loader.
// ----------------------------------------------------------------------------
interface ref_mem_loader_if;
    import ref_mem_pkg::*;

    logic [ROW_W-1:0] pix_in;
    logic             pix_valid;
    logic             pix_ready;

    modport master (
        output pix_in,
        output pix_valid,
        input  pix_ready
    );

    modport slave (
        input  pix_in,
        input  pix_valid,
        output pix_ready
    );

endinterface : ref_mem_loader_if

// File: rtl/ref_mem_loader_bank_mask.sv
// ----------------------------------------------------------------------------
// bank_mask_dec
// Turns a row slot (row index mod ROW_GROUP) into the bank write mask:
// COL_SLOTS contiguous bits starting at bank slot*COL_SLOTS. Combinational.
//   slot : row slot 0..ROW_GROUP-1
//   mask : active-high bank mask, BANKS bits
// ----------------------------------------------------------------------------
module bank_mask_dec
    import ref_mem_pkg::*;
(
    input  logic [SLOT_W-1:0] slot,
    output logic [BANKS-1:0]  mask
);

    always_comb begin
        mask = '0;
        for (int j = 0; j < ROW_GROUP; j++) begin
            if (slot == SLOT_W'(j)) begin
                mask[j*COL_SLOTS +: COL_SLOTS] = '1;
            end
        end
    end

endmodule : bank_mask_dec

// File: rtl/ref_mem_loader.sv
// ----------------------------------------------------------------------------
// ref_mem_loader
// Write-side sequencer for the 32-bank reference memory. Accepts rows of
// 32 pixels on a valid/ready stream and turns each into one registered
// memory write: row r goes to banks 4*(r mod 8)..+3 at entry
// (start_entry + r/8) mod DEPTH. The entry pointer wraps at DEPTH so
// repeated loads recycle the oldest 8-row groups of a sliding window.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   start             : one-cycle load request, honoured only in IDLE
//   num_rows          : rows to load (sampled on start), 0..8*DEPTH
//   start_entry       : first bank entry (sampled on start), 0..DEPTH-1
//   pix               : row stream (slave side)
//   ref_input         : write data to the reference memory
//   Bank_sel          : per-bank write enable, one-cycle pulse per row
//   write_address_all : AW-bit write address per bank, all equal
//   busy              : load in progress (LOAD or DONE)
//   load_done         : one-cycle pulse, coincides with the last write
// ----------------------------------------------------------------------------
module ref_mem_loader
    import ref_mem_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [CNT_W-1:0]      num_rows,
    input  logic [AW-1:0]         start_entry,
    ref_mem_loader_if.slave       pix,
    output logic [ROW_W-1:0]      ref_input,
    output logic [BANKS-1:0]      Bank_sel,
    output logic [AW*BANKS-1:0]   write_address_all,
    output logic                  busy,
    output logic                  load_done
);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   rows_total;
    logic [CNT_W-1:0]   row_cnt;
    logic [AW-1:0]      entry_ptr;
    logic               hs_p0;
    logic               last_row_p0;
    logic [BANKS-1:0]   mask_p0;

    // Entry pointer wraps at DEPTH, not at 2^AW.
    function automatic logic [AW-1:0] next_entry(input logic [AW-1:0] e);
        if (e == AW'(DEPTH - 1)) begin
            return '0;
        end
        return e + AW'(1);
    endfunction

    assign hs_p0       = pix.pix_valid & pix.pix_ready;
    // rows_total >= 1 whenever this matters (LOAD is never entered with 0).
    assign last_row_p0 = ((row_cnt + CNT_W'(1)) == rows_total);

    bank_mask_dec u_mask_dec (
        .slot (row_cnt[SLOT_W-1:0]),
        .mask (mask_p0)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (num_rows == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (hs_p0 && last_row_p0) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        pix.pix_ready = (state == LOAD);
        busy          = (state != IDLE);
        load_done     = (state == DONE);
    end

    // Stage p0: load parameters, row counter and entry pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rows_total <= '0;
            row_cnt    <= '0;
            entry_ptr  <= '0;
        end else if ((state == IDLE) && start) begin
            rows_total <= num_rows;
            row_cnt    <= '0;
            entry_ptr  <= start_entry;
        end else if (hs_p0) begin
            row_cnt <= row_cnt + CNT_W'(1);
            // Advance after the last row slot so the next row lands in the
            // next entry without a bubble.
            if (row_cnt[SLOT_W-1:0] == SLOT_W'(ROW_GROUP - 1)) begin
                entry_ptr <= next_entry(entry_ptr);
            end
        end
    end

    // Stage p1: registered memory write, Bank_sel pulses for one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_input         <= '0;
            Bank_sel          <= '0;
            write_address_all <= '0;
        end else if (hs_p0) begin
            ref_input         <= pix.pix_in;
            Bank_sel          <= mask_p0;
            write_address_all <= {BANKS{entry_ptr}};
        end else begin
            Bank_sel <= '0;
        end
    end

endmodule : ref_mem_loader

// File: doc/ref_mem_loader.md
# ref_mem_loader

Write-side sequencer for the 32-bank reference memory. It accepts reference-window rows of 32 pixels over a valid/ready stream and maps each row onto the memory's write ports: data bus, per-bank select mask and per-bank write addresses. It sits directly upstream of the reference memory and runs before any read scheduling. It uses a circular entry pointer so successive loads can overwrite the oldest 8-row groups of a sliding search window.

## Interface
Parameters:
- PIXEL, 8, bits per pixel
- BANKS, 32, banks in the reference memory (fixed: 8 row slots × 4 column slots)
- DEPTH, 96, entries per bank (one entry = 8 pixels of one row)
- AW, 7, bank address width

Ports:
- clk  in  1  clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a load; ignored unless IDLE
- num_rows  in  10  rows to load, sampled on start; legal 0..8·DEPTH
- start_entry  in  AW  first bank entry written, sampled on start; legal 0..DEPTH-1
- pix_in  in  32·PIXEL  one row of 32 pixels; pixel 0 in LSBs
- pix_valid  in  1  pix_in valid
- pix_ready  out  1  loader can accept pix_in
- ref_input  out  32·PIXEL  write data to reference memory
- Bank_sel  out  BANKS  active-high write mask; bit j enables bank j
- write_address_all  out  AW·BANKS  write address for bank j in bits [AW·(j+1)-1 : AW·j]
- busy  out  1  high from the cycle after start until done
- load_done  out  1  one-cycle pulse when the load is complete

## Operation
- Row r of a load (0-based) is written to banks 4·(r mod 8) .. 4·(r mod 8)+3. Bank 4·(r mod 8)+k receives pixels 8k..8k+7.
- Entry for row r = (start_entry + floor(r/8)) mod DEPTH. The pointer wraps from DEPTH-1 to 0, never to 2^AW-1.
- All 32 address fields carry the current entry. Only the 4 masked banks write.
- States:
  - IDLE: pix_ready=0. On start, latch num_rows and start_entry, then go to LOAD. If num_rows=0, go straight to DONE.
  - LOAD: pix_ready=1. Each handshake (pix_valid&pix_ready) issues one write and increments the row counter. The handshake that accepts row num_rows-1 moves the FSM to DONE.
  - DONE: one cycle. load_done=1, then return to IDLE.
- A final partial group (num_rows not a multiple of 8) leaves the remaining row slots of that entry unwritten. No padding is written.
- pix_valid outside LOAD is ignored; no write occurs.
- start during LOAD or DONE is ignored.

## Timing
- Reset values: pix_ready=0, busy=0, load_done=0, Bank_sel=0, ref_input=0, write_address_all=0, FSM=IDLE, row counter=0, entry pointer=0.
- Write outputs are registered. A handshake in cycle t drives ref_input/Bank_sel/write_address_all in cycle t+1 for exactly one cycle. Bank_sel returns to 0 in t+2 unless another handshake occurred in t+1.
- Throughput is one row per cycle with pix_valid held high. Back-to-back rows crossing an 8-row boundary advance the entry with no bubble.
- The last write (cycle t+1) and load_done (cycle t+1) coincide. busy falls in t+2.
- With num_rows=0, load_done pulses the cycle after start and no write occurs.
- Reset asserted mid-load aborts immediately. All outputs return to reset values and no load_done is issued; partial data in memory is not recovered.

## Structure
- Shared package ref_mem_pkg: PIXEL, BANKS, DEPTH, AW, ROW_GROUP=8, COL_SLOTS=4, FSM state enum (IDLE, LOAD, DONE).
- One sub-module, bank_mask_dec: (r mod 8) → 32-bit mask with 4 contiguous bits set; purely combinational.
- Entry-pointer modulo-DEPTH increment stays in the top level.

## Test plan
- num_rows=16, start_entry=0, continuous valid: 16 writes on consecutive cycles. Rows 0–7 use Bank_sel 0x0000000F..0xF0000000 at address 0; rows 8–15 repeat the masks at address 1. load_done coincides with the 16th write.
- num_rows=16, start_entry=95: rows 0–7 go to address 95 and rows 8–15 to address 0 (wrap). Address 96 never appears.
- num_rows=10 with pix_valid toggling every other cycle: exactly 10 writes. Rows 8–9 use masks 0x0000000F and 0x000000F0 at address start_entry+1. Bank_sel=0 on stall cycles.
- num_rows=0: load_done pulses one cycle after start, Bank_sel stays 0, and pix_ready never rises.
- rst_n low after 5 rows of a 16-row load: all outputs read 0 in the same cycle. A new start then begins at row 0 with the newly sampled start_entry.
- Extra start pulses during LOAD and pix_valid pulses while IDLE produce no writes and no state change.
